// File: rtl/afg_pipe_pkg.sv
// rtl/afg_pipe_pkg.sv - shared constants and helpers for the waveform address pipeline
package afg_pipe_pkg;

    localparam int ADDR_W       = 14;
    localparam int ADDR_DLY_MAX = 8;

    // Smallest r such that 2**r >= n; sizes the delay-select field.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one word+valid register stage of the address delay line
module delay_stage #(
    parameter int WIDTH = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr_valid,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_d,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_d;
    logic             r_valid;

    // Data moves only when enabled; the valid-clear wins over both shift and hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d     <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_en) begin
                r_d <= i_d;
            end
            if (i_clr_valid) begin
                r_valid <= 1'b0;
            end else if (i_en) begin
                r_valid <= i_valid;
            end
        end
    end

    assign o_d     = r_d;
    assign o_valid = r_valid;

endmodule

// File: rtl/addr_delay_line.sv
// rtl/addr_delay_line.sv - stallable, flushable delay line with run-time tap select
module addr_delay_line
    import afg_pipe_pkg::*;
#(
    parameter int WIDTH     = ADDR_W,
    parameter int MAX_DEPTH = ADDR_DLY_MAX,
    parameter int SEL_W     = clog2(MAX_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    input  logic [SEL_W-1:0] i_delay_sel,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    output logic             o_primed,
    output logic [SEL_W:0]   o_fill
);

    localparam logic [SEL_W:0]   MAX_FILL = (SEL_W + 1)'(MAX_DEPTH);
    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(MAX_DEPTH - 1);
    localparam logic [SEL_W:0]   FILL_ONE = {{SEL_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_stage_d [MAX_DEPTH];
    logic             w_stage_v [MAX_DEPTH];
    logic [SEL_W-1:0] w_tap;
    logic [SEL_W:0]   w_tap_ext;
    logic [SEL_W:0]   r_fill;

    // Stage 0 takes the input word; every later stage takes its predecessor.
    for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_en        (i_en),
                .i_clr_valid (i_flush),
                .i_d         (i_din),
                .i_valid     (i_din_valid),
                .o_d         (w_stage_d[g]),
                .o_valid     (w_stage_v[g])
            );
        end else begin : g_body
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_en        (i_en),
                .i_clr_valid (i_flush),
                .i_d         (w_stage_d[g-1]),
                .i_valid     (w_stage_v[g-1]),
                .o_d         (w_stage_d[g]),
                .o_valid     (w_stage_v[g])
            );
        end
    end

    // Selects beyond the last physical stage fall back to the deepest tap.
    assign w_tap     = ({1'b0, i_delay_sel} < MAX_FILL) ? i_delay_sel : LAST_TAP;
    assign w_tap_ext = {1'b0, w_tap};

    // Count enabled shifts since reset/flush; stops at the physical depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fill <= '0;
        end else if (i_flush) begin
            r_fill <= '0;
        end else if (i_en && (r_fill != MAX_FILL)) begin
            r_fill <= r_fill + FILL_ONE;
        end
    end

    // Outputs come only from stage registers, so Din never reaches them combinationally.
    assign o_dout       = w_stage_d[w_tap];
    assign o_dout_valid = w_stage_v[w_tap];
    assign o_primed     = (r_fill > w_tap_ext);
    assign o_fill       = r_fill;

endmodule

// File: tb/tb_addr_delay_line.sv
// tb/tb_addr_delay_line.sv - directed vector bench for addr_delay_line
module tb_addr_delay_line;

    logic        clk;
    logic        rst, en, flush, dv;
    logic [13:0] din;
    logic [2:0]  sel;
    logic [13:0] dout;
    logic        dout_v, primed;
    logic [3:0]  fill;

    logic        rst6, en6, flush6, dv6;
    logic [13:0] din6;
    logic [2:0]  sel6;
    logic [13:0] dout6;
    logic        dout_v6, primed6;
    logic [3:0]  fill6;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic        flush;
        logic        dv;
        logic [13:0] din;
        logic [2:0]  sel;
        logic [13:0] e_dout;
        logic        e_v;
        logic        e_p;
        logic [3:0]  e_fill;
    } vec_t;

    vec_t vq[$];

    addr_delay_line dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush),
        .i_din(din), .i_din_valid(dv), .i_delay_sel(sel),
        .o_dout(dout), .o_dout_valid(dout_v), .o_primed(primed), .o_fill(fill)
    );

    addr_delay_line #(.MAX_DEPTH(6)) dut6 (
        .i_clk(clk), .i_rst(rst6), .i_en(en6), .i_flush(flush6),
        .i_din(din6), .i_din_valid(dv6), .i_delay_sel(sel6),
        .o_dout(dout6), .o_dout_valid(dout_v6), .o_primed(primed6), .o_fill(fill6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [13:0] e_d, input logic e_v,
                        input logic e_p, input logic [3:0] e_f);
        chk({name, ".dout"},   32'(dout),   32'(e_d));
        chk({name, ".valid"},  32'(dout_v), 32'(e_v));
        chk({name, ".primed"}, 32'(primed), 32'(e_p));
        chk({name, ".fill"},   32'(fill),   32'(e_f));
    endtask

    task automatic chk6(input string name, input logic [13:0] e_d, input logic e_v,
                        input logic e_p, input logic [3:0] e_f);
        chk({name, ".dout"},   32'(dout6),   32'(e_d));
        chk({name, ".valid"},  32'(dout_v6), 32'(e_v));
        chk({name, ".primed"}, 32'(primed6), 32'(e_p));
        chk({name, ".fill"},   32'(fill6),   32'(e_f));
    endtask

    task automatic step8(input logic i_en, input logic i_fl, input logic i_dv,
                         input logic [13:0] i_d, input logic [2:0] i_s);
        en = i_en; flush = i_fl; dv = i_dv; din = i_d; sel = i_s;
        @(posedge clk);
        #1;
    endtask

    task automatic step6(input logic [13:0] i_d, input logic [2:0] i_s);
        en6 = 1'b1; flush6 = 1'b0; dv6 = 1'b1; din6 = i_d; sel6 = i_s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic f, input logic v, input logic [13:0] d,
                       input logic [2:0] s, input logic [13:0] ed, input logic ev,
                       input logic ep, input logic [3:0] ef);
        vq.push_back('{e, f, v, d, s, ed, ev, ep, ef});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; dv = 1'b0; din = '0; sel = 3'd2;
        rst6 = 1'b1; en6 = 1'b0; flush6 = 1'b0; dv6 = 1'b0; din6 = '0; sel6 = 3'd7;

        // latency at tap 2, then stall, then resume with saturation
        add(1,0,1,14'h001,2, 14'h000,0,0,1);
        add(1,0,1,14'h002,2, 14'h000,0,0,2);
        add(1,0,1,14'h003,2, 14'h001,1,1,3);
        add(1,0,1,14'h004,2, 14'h002,1,1,4);
        for (int i = 0; i < 4; i++) add(0,0,1,14'h3FF,2, 14'h002,1,1,4);
        add(1,0,1,14'h005,2, 14'h003,1,1,5);
        add(1,0,1,14'h006,2, 14'h004,1,1,6);
        add(1,0,1,14'h007,2, 14'h005,1,1,7);
        add(1,0,1,14'h008,2, 14'h006,1,1,8);
        add(1,0,1,14'h009,2, 14'h007,1,1,8);
        // tap 4 stream, flush with En=1, refill
        add(1,0,1,14'h100,4, 14'h006,1,1,8);
        add(1,0,1,14'h101,4, 14'h007,1,1,8);
        add(1,0,1,14'h102,4, 14'h008,1,1,8);
        add(1,0,1,14'h103,4, 14'h009,1,1,8);
        add(1,0,1,14'h104,4, 14'h100,1,1,8);
        add(1,1,1,14'h105,4, 14'h101,0,0,0);
        add(1,0,1,14'h106,4, 14'h102,0,0,1);
        add(1,0,1,14'h107,4, 14'h103,0,0,2);
        add(1,0,1,14'h108,4, 14'h104,0,0,3);
        add(1,0,1,14'h109,4, 14'h105,0,0,4);
        add(1,0,1,14'h10A,4, 14'h106,1,1,5);
        // bubbles at tap 1
        add(1,0,1,14'h201,1, 14'h10A,1,1,6);
        add(1,0,0,14'h202,1, 14'h201,1,1,7);
        add(1,0,1,14'h203,1, 14'h202,0,1,8);
        add(1,0,1,14'h204,1, 14'h203,1,1,8);
        // flush while stalled: data holds, valids and fill clear
        add(0,1,1,14'h300,1, 14'h203,0,0,0);
        add(0,0,1,14'h301,1, 14'h203,0,0,0);
        add(1,0,1,14'h302,1, 14'h204,0,0,1);
        add(1,0,1,14'h303,1, 14'h302,1,1,2);

        #2;
        chk8("reset_state", 14'h000, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; rst6 = 1'b0;
        chk8("after_release", 14'h000, 0, 0, 0);

        foreach (vq[i]) begin
            step8(vq[i].en, vq[i].flush, vq[i].dv, vq[i].din, vq[i].sel);
            chk8($sformatf("vec%0d", i), vq[i].e_dout, vq[i].e_v, vq[i].e_p, vq[i].e_fill);
        end

        // fill stage i with 0x0A00+i, then move the tap without a clock edge
        for (int k = 7; k >= 0; k--) step8(1, 0, 1, 14'h0A00 + 14'(k), 3'd7);
        en = 1'b0;
        chk8("tap7", 14'h0A07, 1, 1, 8);
        sel = 3'd0; #1;
        chk8("tap0_same_cycle", 14'h0A00, 1, 1, 8);
        sel = 3'd3; #1;
        chk8("tap3_same_cycle", 14'h0A03, 1, 1, 8);

        // asynchronous reset between edges clears outputs immediately
        rst = 1'b1; #1;
        chk8("async_reset", 14'h000, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step8(1, 0, 1, 14'h0555, 3'd0);
        chk8("first_after_reset", 14'h0555, 1, 1, 1);

        // clamp on the 6-deep instance: select 7 maps to tap 5
        for (int k = 5; k >= 1; k--) step6(14'h0B00 + 14'(k), 3'd7);
        chk6("clamp_not_primed", 14'h000, 0, 0, 5);
        step6(14'h0B00, 3'd7);
        chk6("clamp_tap5", 14'h0B05, 1, 1, 6);
        step6(14'h0B10, 3'd7);
        chk6("clamp_saturate", 14'h0B04, 1, 1, 6);
        sel6 = 3'd4; #1;
        chk6("tap4_dut6", 14'h0B03, 1, 1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_delay_line.md
Name: addr_delay_line

Overview:
- Parametrised, stallable address/data delay line for the waveform-memory address path.
- Delays a WIDTH-bit word plus a valid flag by a run-time selectable 1..MAX_DEPTH cycles.
- Aligns the sample-address stream with the downstream memory and DAC pipeline latency.
- Extends the fixed 3-stage 14-bit address buffer with:
  - width and depth parameters;
  - a clock enable (stall);
  - valid tracking;
  - a synchronous flush;
  - a fill/primed indicator.

Parameters:
- WIDTH, 14: data/address word width in bits.
- MAX_DEPTH, 8: number of physical register stages; maximum delay. Must be ≥2.
- SEL_W, 3: width of DelaySel; SEL_W = clog2(MAX_DEPTH).

Ports:
- Clock  input  1  system clock; rising edge.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  advance enable. 1 = all stages shift; 0 = every stage and the fill counter hold.
- Flush  input  1  synchronous clear of all valid flags and the fill counter.
- Din  input  WIDTH  word entering stage 0.
- DinValid  input  1  qualifies Din.
- DelaySel  input  SEL_W  selected delay minus one. Tap k gives a delay of k+1 enabled cycles.
- Dout  output  WIDTH  data at the selected tap.
- DoutValid  output  1  valid flag at the selected tap.
- Primed  output  1  1 when the selected tap holds a word shifted in since the last reset or flush.
- Fill  output  SEL_W+1  count of enabled shifts since reset/flush, saturating at MAX_DEPTH.

Behaviour:
- Reset (async, Reset=1):
  - all stage data regs = 0 and all valid regs = 0;
  - Fill = 0, so Dout = 0, DoutValid = 0 and Primed = 0 immediately;
  - Reset mid-stream discards all in-flight words;
  - first capture is on the first rising edge after Reset deasserts.
- Shift, on a rising edge with En=1:
  - stage[0] ← {DinValid, Din};
  - stage[i] ← stage[i-1] for i = 1..MAX_DEPTH-1.
- Stall: with En=0, all stages, valids and Fill hold their values.
- Output:
  - Dout and DoutValid are a combinational mux of stage[tap] registers only.
  - There is no combinational path from Din or DinValid to any output.
- Tap selection:
  - tap = DelaySel when DelaySel < MAX_DEPTH; otherwise tap = MAX_DEPTH-1 (clamp).
  - Latency is tap+1 enabled rising edges.
  - With MAX_DEPTH=8 and DelaySel=2, behaviour is identical to the legacy 3-stage buffer.
- Changing DelaySel:
  - takes effect on the outputs in the same cycle (mux only);
  - stage contents are untouched;
  - the stream is neither duplicated nor re-primed.
- Flush, on a rising edge with Flush=1:
  - all valid regs ← 0 and Fill ← 0, regardless of En;
  - data regs shift normally if En=1, otherwise they hold;
  - a word presented on Din in the flush cycle is captured as invalid.
- Flush and Reset together: Reset dominates.
- Fill:
  - increments by 1 on each edge with En=1 and Flush=0;
  - saturates at MAX_DEPTH and never wraps.
- Primed = (Fill > tap). It is registered-derived and updates with DelaySel in the same cycle.
- DoutValid is independent of Primed. It reflects the per-word valid flag, so bubbles (DinValid=0) propagate as DoutValid=0.
- Width rule: Fill comparison uses zero-extension of tap to SEL_W+1 bits.

Decomposition:
- Shared package, afg_pipe_pkg:
  - default constants ADDR_W=14 and ADDR_DLY_MAX=8;
  - a clog2 function for SEL_W derivation.
- One sub-module, delay_stage:
  - a WIDTH+1-bit register with async reset, enable, and a synchronous valid-clear;
  - instantiated MAX_DEPTH times by a generate loop.
- Fill counter, clamp and tap mux stay in the top level.

Test Plan:
- Reset then latency: Reset pulse; DelaySel=2, En=1; Din = 0x0001, 0x0002, … with DinValid=1.
  - Dout=0x0001, DoutValid=1 first visible after the 3rd rising edge.
  - Primed rises in the same cycle; Fill = 3.
- Stall: mid-stream, hold En=0 for 4 cycles.
  - Dout, DoutValid and Fill frozen.
  - Resume: sequence continues with no gap or duplicate.
- Flush with En=1: stream 0x0100..0x0107 at DelaySel=4, assert Flush for one cycle.
  - DoutValid=0, Primed=0 and Fill=0 next cycle.
  - First post-flush word appears valid 5 edges after its entry.
- Tap change and clamp: full pipe of 0x0A00+i at stage i, DelaySel 7→0.
  - Dout jumps from stage 7 to stage 0 data in the same cycle.
  - DelaySel=9 with MAX_DEPTH=8 is not reachable (SEL_W=3); instead check the clamp with parameter override MAX_DEPTH=6, DelaySel=7 → tap 5.
- Bubbles: DinValid pattern 1,0,1 with DelaySel=1.
  - DoutValid 1,0,1 after 2 edges.
  - Primed stays 1 throughout.
- Async reset mid-stream: assert Reset between clock edges.
  - Dout=0, DoutValid=0, Fill=0 immediately, without waiting for a clock edge.
